mprj_wb_splitter: RTL and testbench

Parametrised user-project Wishbone splitter between the management core's exported Wishbone master and up to eight user-project slave channels. It decodes a fixed address window into channels and gates each channel's return path with a per-channel input enable. It bounds every access with a timeout, so a dead or disabled user project terminates with a bus error instead of hanging the CPU. Error events are counted and classified for firmware.

---
 rtl/mprj_wb_splitter.sv | 185 ++++++++++++++++++
 tb/tb_mprj_wb_splitter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_wb_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mprj_wb_splitter: management Wishbone master to NUM_CH user-project slaves, |
// | with window decode, per-channel return gating, timeout and error counting.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mprj_wb_splitter #(
  parameter int          NUM_CH   = 4,
  parameter int          CH_LSB   = 20,
  parameter logic [31:0] WIN_BASE = 32'h3000_0000,
  parameter logic [31:0] WIN_MASK = 32'hF000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic                   core_clk,
  input  logic                   core_rst,
  input  logic [NUM_CH-1:0]      ch_ena,
  input  logic                   m_cyc_i,
  input  logic                   m_stb_i,
  input  logic                   m_we_i,
  input  logic [3:0]             m_sel_i,
  input  logic [31:0]            m_adr_i,
  input  logic [31:0]            m_dat_i,
  output logic                   m_ack_o,
  output logic                   m_err_o,
  output logic [31:0]            m_dat_o,
  output logic [NUM_CH-1:0]      s_cyc_o,
  output logic [NUM_CH-1:0]      s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [31:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [NUM_CH-1:0]      s_iena_o,
  input  logic [NUM_CH-1:0]      s_ack_i,
  input  logic [32*NUM_CH-1:0]   s_dat_i,
  output logic                   busy_o,
  input  logic                   err_clr_i,
  output logic [7:0]             err_cnt_o,
  output logic [1:0]             err_cause_o
);

  localparam int          CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW:0] c_num_ch  = NUM_CH[CW:0];
  localparam logic [31:0] c_timeout = TIMEOUT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] c_cause_miss = 2'b01;
  localparam logic [1:0] c_cause_dis  = 2'b10;
  localparam logic [1:0] c_cause_tmo  = 2'b11;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_idx;
  logic [31:0]       r_cnt;
  logic              r_ack;
  logic              r_err;
  logic [1:0]        r_cause;
  logic [31:0]       r_m_dat;
  logic              r_s_we;
  logic [3:0]        r_s_sel;
  logic [31:0]       r_s_adr;
  logic [31:0]       r_s_dat;
  logic [7:0]        r_err_cnt;
  logic [1:0]        r_err_cause;

  logic [CW-1:0]     w_idx;
  logic              w_hit;
  logic              w_idx_ok;
  logic [NUM_CH-1:0] w_dec;
  logic [NUM_CH-1:0] w_sel;
  logic              w_ena_hit;
  logic              w_ack;
  logic [31:0]       w_rdat;

  assign w_idx    = m_adr_i[CH_LSB +: CW];
  assign w_hit    = ((m_adr_i & WIN_MASK) == WIN_BASE);
  assign w_idx_ok = ({1'b0, w_idx} < c_num_ch);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_dec[k] = (w_idx == CW'(k));
    assign w_sel[k] = (r_idx == CW'(k));
  end

  assign w_ena_hit = |(w_dec & ch_ena);
  // A disabled channel's ack is masked so the access can only end by timeout or abort.
  assign w_ack     = |(w_sel & s_ack_i & ch_ena);

  always_comb begin
    w_rdat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_sel[k]) w_rdat = s_dat_i[32*k +: 32];
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_cause <= 2'b00;
      r_m_dat <= '0;
      r_s_we  <= 1'b0;
      r_s_sel <= '0;
      r_s_adr <= '0;
      r_s_dat <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            r_s_we  <= m_we_i;
            r_s_sel <= m_sel_i;
            r_s_adr <= m_adr_i;
            r_s_dat <= m_dat_i;
            r_idx   <= w_idx;
            r_cnt   <= 32'd1;
            if (!w_hit || !w_idx_ok) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_cause <= c_cause_miss;
            end else if (!w_ena_hit) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_cause <= c_cause_dis;
            end else begin
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // Master abort outranks ack and timeout and leaves the counter alone.
          if (!m_cyc_i) begin
            r_state <= S_IDLE;
          end else if (w_ack) begin
            r_state <= S_DONE;
            r_ack   <= 1'b1;
            if (!r_s_we) r_m_dat <= w_rdat;
          end else if ((c_timeout != 32'd0) && (r_cnt == c_timeout)) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
            r_cause <= c_cause_tmo;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_err_cnt   <= '0;
      r_err_cause <= 2'b00;
    end else if (r_err) begin
      r_err_cause <= r_cause;
      if (err_clr_i)                r_err_cnt <= 8'd1;
      else if (r_err_cnt != 8'hFF)  r_err_cnt <= r_err_cnt + 8'd1;
    end else if (err_clr_i) begin
      r_err_cnt   <= '0;
      r_err_cause <= 2'b00;
    end
  end

  assign busy_o      = (r_state == S_BUSY);
  assign s_cyc_o     = busy_o ? w_sel : '0;
  assign s_stb_o     = busy_o ? w_sel : '0;
  assign s_iena_o    = busy_o ? w_sel : '0;
  assign m_ack_o     = r_ack;
  assign m_err_o     = r_err;
  assign m_dat_o     = r_m_dat;
  assign s_we_o      = r_s_we;
  assign s_sel_o     = r_s_sel;
  assign s_adr_o     = r_s_adr;
  assign s_dat_o     = r_s_dat;
  assign err_cnt_o   = r_err_cnt;
  assign err_cause_o = r_err_cause;

endmodule
`default_nettype wire

// File: tb/tb_mprj_wb_splitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mprj_wb_splitter: directed scoreboard bench for mprj_wb_splitter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mprj_wb_splitter;

  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 8;

  logic                 core_clk;
  logic                 core_rst;
  logic [NUM_CH-1:0]    ch_ena;
  logic                 m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]           m_sel_i;
  logic [31:0]          m_adr_i, m_dat_i;
  logic                 m_ack_o, m_err_o;
  logic [31:0]          m_dat_o;
  logic [NUM_CH-1:0]    s_cyc_o, s_stb_o, s_iena_o;
  logic                 s_we_o;
  logic [3:0]           s_sel_o;
  logic [31:0]          s_adr_o, s_dat_o;
  logic [NUM_CH-1:0]    s_ack_i;
  logic [32*NUM_CH-1:0] s_dat_i;
  logic                 busy_o;
  logic                 err_clr_i;
  logic [7:0]           err_cnt_o;
  logic [1:0]           err_cause_o;

  mprj_wb_splitter #(
    .NUM_CH(NUM_CH), .CH_LSB(20), .WIN_BASE(32'h3000_0000),
    .WIN_MASK(32'hF000_0000), .TIMEOUT(TIMEOUT)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst), .ch_ena(ch_ena),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_iena_o(s_iena_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .busy_o(busy_o), .err_clr_i(err_clr_i),
    .err_cnt_o(err_cnt_o), .err_cause_o(err_cause_o)
  );

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_cnt  = 0;
  logic [1:0]  exp_cause = 2'b00;
  logic [31:0] last_dat  = 32'h0;

  // Slave responders: channel k acks slv_d[k] cycles after its stb rises.
  logic [NUM_CH-1:0] slv_en;
  int                slv_d   [NUM_CH];
  int                slv_age [NUM_CH];

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    s_ack_i = '0;
    for (int k = 0; k < NUM_CH; k++) slv_age[k] = 0;
    forever begin
      @(negedge core_clk);
      for (int k = 0; k < NUM_CH; k++) begin
        if (s_stb_o[k]) begin
          s_ack_i[k] = slv_en[k] && (slv_age[k] == slv_d[k]);
          slv_age[k] = slv_age[k] + 1;
        end else begin
          s_ack_i[k] = 1'b0;
          slv_age[k] = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_err_regs(input string tag);
    check({tag, "_cnt"}, {24'h0, err_cnt_o}, 32'(exp_cnt));
    check({tag, "_cause"}, {30'h0, err_cause_o}, {30'h0, exp_cause});
  endtask

  // One master access, started at a negedge; expectation goes to the scoreboard first.
  task automatic access(input string tag, input logic [31:0] adr, input logic we,
                        input logic [31:0] wdat, input logic [3:0] sel,
                        input logic exp_ack, input logic [1:0] cause, input int lat,
                        input logic [31:0] rdat, input logic [3:0] stb_exp,
                        input logic clr_on_done);
    exp_t e;
    int   n;
    logic got;
    e.ack = exp_ack;
    e.err = !exp_ack;
    e.dat = (exp_ack && !we) ? rdat : last_dat;
    e.lat = lat;
    sb.push_back(e);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
    m_adr_i = adr;  m_dat_i = wdat; m_sel_i = sel;
    n = 0; got = 1'b0;
    while (!got && n < 64) begin
      @(negedge core_clk);
      n++;
      if (n == 1) check({tag, "_stb"}, {28'h0, s_stb_o}, {28'h0, stb_exp});
      if (m_ack_o || m_err_o) got = 1'b1;
    end
    check({tag, "_done"}, {31'h0, got}, 32'h1);
    if (got) begin
      e = sb.pop_front();
      check({tag, "_ack"}, {31'h0, m_ack_o}, {31'h0, e.ack});
      check({tag, "_err"}, {31'h0, m_err_o}, {31'h0, e.err});
      check({tag, "_dat"}, m_dat_o, e.dat);
      check({tag, "_lat"}, 32'(n), 32'(e.lat));
      check({tag, "_idle_stb"}, {28'h0, s_stb_o}, 32'h0);
    end
    if (clr_on_done) err_clr_i = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    if (e.err) begin
      exp_cnt   = clr_on_done ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
      exp_cause = cause;
    end
    if (e.ack && !we) last_dat = rdat;
    @(negedge core_clk);
    err_clr_i = 1'b0;
    check_err_regs(tag);
  endtask

  initial begin
    int flags;
    core_rst = 1'b0; ch_ena = 4'hF; err_clr_i = 1'b0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0; m_sel_i = 4'h0;
    m_adr_i = 32'h0; m_dat_i = 32'h0;
    slv_en = 4'hF;
    for (int k = 0; k < NUM_CH; k++) slv_d[k] = 0;
    s_dat_i = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};
    #1 core_rst = 1'b1;
    #20;
    check("rst_ackerr", {30'h0, m_ack_o, m_err_o}, 32'h0);
    check("rst_mdat", m_dat_o, 32'h0);
    check("rst_sreq", {20'h0, s_cyc_o, s_stb_o, s_iena_o}, 32'h0);
    check("rst_shared", s_adr_o | s_dat_o | {27'h0, s_we_o, s_sel_o}, 32'h0);
    check("rst_busy_err", {21'h0, busy_o, err_cnt_o, err_cause_o}, 32'h0);
    @(negedge core_clk);
    core_rst = 1'b0;
    @(negedge core_clk);

    slv_d[1] = 2;
    access("rd_ch1", 32'h3010_0000, 1'b0, 32'h0, 4'hF, 1'b1, 2'b00, 4, 32'hDEAD_BEEF, 4'b0010, 1'b0);

    slv_d[3] = 0;
    access("wr_ch3", 32'h3030_0004, 1'b1, 32'h1234_5678, 4'hC, 1'b1, 2'b00, 2, 32'h0, 4'b1000, 1'b0);
    check("wr_sdat", s_dat_o, 32'h1234_5678);
    check("wr_ssel", {28'h0, s_sel_o}, 32'hC);
    check("wr_sadr", s_adr_o, 32'h3030_0004);
    check("wr_swe", {31'h0, s_we_o}, 32'h1);

    access("miss", 32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 2'b01, 1, 32'h0, 4'b0000, 1'b0);

    ch_ena = 4'b1101;
    access("dis_ch1", 32'h3010_0000, 1'b0, 32'h0, 4'hF, 1'b0, 2'b10, 1, 32'h0, 4'b0000, 1'b0);

    slv_en[0] = 1'b0;
    access("tmo_ch0", 32'h3000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 2'b11, 1 + TIMEOUT, 32'h0, 4'b0001, 1'b0);

    // Master abort three cycles into BUSY.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h3000_0000;
    repeat (3) @(negedge core_clk);
    check("abort_busy", {31'h0, busy_o}, 32'h1);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge core_clk);
    check("abort_stb", {28'h0, s_stb_o}, 32'h0);
    check("abort_idle", {31'h0, busy_o}, 32'h0);
    flags = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_ack_o || m_err_o) flags++;
      @(negedge core_clk);
    end
    check("abort_quiet", 32'(flags), 32'h0);
    check_err_regs("abort");

    slv_en[0] = 1'b1; slv_d[0] = TIMEOUT - 1;
    access("ack_at_tmo", 32'h3000_0000, 1'b0, 32'h0, 4'hF, 1'b1, 2'b00, 1 + TIMEOUT, 32'h1111_0000, 4'b0001, 1'b0);

    slv_d[2] = 1;
    access("rd_ch2", 32'h3020_0008, 1'b0, 32'h0, 4'hF, 1'b1, 2'b00, 3, 32'h2222_2222, 4'b0100, 1'b0);

    err_clr_i = 1'b1;
    @(negedge core_clk);
    err_clr_i = 1'b0;
    exp_cnt = 0; exp_cause = 2'b00;
    check_err_regs("clr_alone");

    for (int i = 0; i < 256; i++)
      access("sat", 32'h4000_0000 + 32'(i), 1'b0, 32'h0, 4'hF, 1'b0, 2'b01, 1, 32'h0, 4'b0000, 1'b0);
    check("sat_255", {24'h0, err_cnt_o}, 32'd255);

    access("clr_coinc", 32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 2'b01, 1, 32'h0, 4'b0000, 1'b1);

    // Reset pulsed in the middle of a silent access.
    ch_ena = 4'hF; slv_en[0] = 1'b0;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h3000_0000;
    repeat (2) @(negedge core_clk);
    check("mid_busy", {31'h0, busy_o}, 32'h1);
    #2 core_rst = 1'b1;
    #1;
    check("mrst_req", {21'h0, busy_o, s_cyc_o, s_stb_o, s_iena_o}, 32'h0);
    check("mrst_m", m_dat_o | {30'h0, m_ack_o, m_err_o}, 32'h0);
    check("mrst_shared", s_adr_o | s_dat_o | {27'h0, s_we_o, s_sel_o}, 32'h0);
    check("mrst_err", {22'h0, err_cnt_o, err_cause_o}, 32'h0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge core_clk);
    core_rst = 1'b0;
    exp_cnt = 0; exp_cause = 2'b00; last_dat = 32'h0;
    @(negedge core_clk);
    slv_d[3] = 0;
    access("post_rst", 32'h3030_0000, 1'b0, 32'h0, 4'hF, 1'b1, 2'b00, 2, 32'h3333_3333, 4'b1000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
